mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- Memory-access plus MEM/WB pipeline register, directly upstream of the register file.
- Performs loads and stores against an external data-memory port that answers with a ready handshake.
- Freezes the upstream pipeline while an access is outstanding.
- Registers the final writeback triple (Result_WB, Dest_wb, writeBackEn), which drives the register file's write port. The register file writes on negedge, so a result registered at posedge N is written in the same cycle.

Parameters:
- MEM_BASE, 1024: byte offset subtracted from the ALU result to form the memory address.
- TIMEOUT, 16: maximum WAIT cycles without mem_ready before the access is aborted (≥ 2).

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  an instruction is present from EX/MEM
- mem_r_en_in  in  1  instruction is a load
- mem_w_en_in  in  1  instruction is a store
- wb_en_in  in  1  instruction writes a register
- dest_in  in  4  destination register index
- alu_res_in  in  32  ALU result (the address for memory ops)
- val_rm_in  in  32  store data
- mem_req  out  1  memory request, held until completion
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  alu_res − MEM_BASE, latched
- mem_wdata  out  32  latched store data
- mem_rdata  in  32  read data, valid when mem_ready = 1
- mem_ready  in  1  access complete this cycle
- freeze  out  1  stall upstream stages (combinational)
- mem_err  out  1  one-cycle pulse on timeout
- Result_WB  out  32  writeback value
- Dest_wb  out  4  writeback register index
- writeBackEn  out  1  writeback enable

Behaviour:
- Reset:
  - state = IDLE; all registered outputs are 0 (mem_req, mem_we, mem_addr, mem_wdata, Result_WB, Dest_wb, writeBackEn, mem_err, wait counter).
  - freeze is forced to 0 while rst = 1.
  - Reset mid-access drops mem_req at the next edge and discards the access.
- Definitions:
  - mem_op = valid_in & (mem_r_en_in | mem_w_en_in).
  - If both mem_r_en_in and mem_w_en_in are set, the access is treated as a store.
- State IDLE:
  - valid_in & !mem_op: Result_WB <= alu_res_in, Dest_wb <= dest_in, writeBackEn <= wb_en_in. Latency is 1 cycle.
  - !valid_in: writeBackEn <= 0 (bubble). Result_WB and Dest_wb hold their values.
  - mem_op: latch addr, wdata, we, dest, wb_en, and the is-load flag. Then mem_req <= 1, counter <= 0, writeBackEn <= 0, and go to WAIT. freeze = 1 in this cycle.
  - mem_ready is ignored in IDLE.
- State WAIT:
  - mem_req, mem_we, mem_addr and mem_wdata are stable.
  - Counter increments every cycle.
  - freeze = !mem_ready & !timeout, where timeout = (counter == TIMEOUT−1).
  - writeBackEn <= 0 every cycle in WAIT until the completion edge.
  - On mem_ready (takes priority over timeout in the same cycle):
    - mem_req <= 0, state <= IDLE.
    - Load: Result_WB <= mem_rdata, Dest_wb <= latched dest, writeBackEn <= latched wb_en.
    - Store: writeBackEn <= 0.
    - Upstream advances on this same edge because freeze = 0.
  - On timeout without ready: mem_req <= 0, writeBackEn <= 0, mem_err <= 1 for one cycle, state <= IDLE.
- Load latency: if mem_ready arrives k cycles after entering WAIT (k ≥ 1), writeBackEn rises k+1 edges after the load is presented.
- Upstream inputs change while freeze = 1: these are a protocol violation. The latched copies are used regardless.
- Arithmetic: mem_addr is 32-bit modulo subtraction with no alignment check. The low two bits are passed through.
- Back-to-back memory ops:
  - The next op is seen in IDLE on the cycle after completion, and WAIT is re-entered.
  - Minimum spacing is one IDLE cycle; mem_req is 0 for at least one cycle between accesses.

Decomposition:
- Shared pipeline package holds:
  - the FSM state encoding (IDLE, WAIT);
  - MEM_BASE;
  - a REG_IDX_W = 4 constant shared with the register file and the EX/MEM stage.
- One natural sub-module: mem_wait_counter, a TIMEOUT-bounded counter with clear/enable/terminal-count outputs.
- The FSM and the writeback register stay in the top module.

Test Plan:
- ALU op: valid=1, wb_en=1, dest=5, alu_res=0x1234, no mem op -> next edge Result_WB=0x1234, Dest_wb=5, writeBackEn=1, freeze stays 0.
- Load with 2-cycle memory: alu_res=1028, dest=3; mem_ready pulses 2 cycles after mem_req rises with rdata=0xDEADBEEF -> mem_addr=4, mem_we=0, freeze high for 2 cycles; then Result_WB=0xDEADBEEF, Dest_wb=3, writeBackEn=1 for one cycle; no earlier writeBackEn.
- Store: alu_res=1032, val_rm=0xA5A5A5A5, ready after 1 cycle -> mem_we=1, mem_addr=8, mem_wdata=0xA5A5A5A5; writeBackEn stays 0 throughout.
- Timeout: load, mem_ready held 0 -> mem_req drops after TIMEOUT=16 WAIT cycles, mem_err pulses 1 cycle, writeBackEn never 1, freeze low on the abort cycle.
- Reset mid-WAIT: rst=1 for 1 cycle during a load -> next edge state IDLE, mem_req=0, writeBackEn=0, freeze=0; a late mem_ready after reset causes no writeback.
- Ready and timeout in the same cycle: ready on counter=15 with rdata=0x77 -> load completes normally (Result_WB=0x77, writeBackEn=1), mem_err stays 0.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions for the MEM/WB stage and its neighbours.
//   state_t   : memory-access FSM encoding (IDLE, WAIT)
//   MEM_BASE  : byte offset removed from the ALU result to form a memory address
//   REG_IDX_W : register index width, shared with the register file and EX/MEM
package mem_wb_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [31:0] MEM_BASE  = 32'd1024;
    localparam int unsigned REG_IDX_W = 4;

endpackage

// File: rtl/mem_wb_stage_wait_counter.sv
// mem_wait_counter: bounded wait-cycle counter for an outstanding memory access.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force the count to zero (takes priority over en)
//   en       : advance the count by one
//   tc       : count has reached TIMEOUT-1 (last permitted wait cycle)
module mem_wait_counter #(
    parameter int unsigned TIMEOUT = 16,
    localparam int unsigned CW     = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory access plus MEM/WB pipeline register feeding the register file.
//   clk, rst                      : clock, synchronous active-high reset
//   valid_in, mem_r_en_in,
//   mem_w_en_in, wb_en_in,
//   dest_in, alu_res_in, val_rm_in: instruction from EX/MEM
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_rdata,
//   mem_ready                     : data-memory port with ready handshake
//   freeze                        : stall upstream while an access is outstanding
//   mem_err                       : one-cycle pulse when an access times out
//   Result_WB, Dest_wb,
//   writeBackEn                   : registered writeback triple to the register file
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter logic [31:0] MEM_BASE = mem_wb_stage_pkg::MEM_BASE,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic                 mem_r_en_in,
    input  logic                 mem_w_en_in,
    input  logic                 wb_en_in,
    input  logic [REG_IDX_W-1:0] dest_in,
    input  logic [31:0]          alu_res_in,
    input  logic [31:0]          val_rm_in,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ready,
    output logic                 freeze,
    output logic                 mem_err,
    output logic [31:0]          Result_WB,
    output logic [REG_IDX_W-1:0] Dest_wb,
    output logic                 writeBackEn
);

    state_t               state;
    logic                 mem_op;
    logic                 timeout;
    logic                 lat_load;
    logic                 lat_wb_en;
    logic [REG_IDX_W-1:0] lat_dest;

    assign mem_op = valid_in & (mem_r_en_in | mem_w_en_in);

    // Counter is held at zero in IDLE so it reads 0 on the first WAIT cycle.
    mem_wait_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_counter (
        .clk (clk),
        .rst (rst),
        .clr (state == IDLE),
        .en  (state == WAIT),
        .tc  (timeout)
    );

    always_comb begin
        freeze = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    freeze = mem_op;
                WAIT:    freeze = !mem_ready && !timeout;
                default: freeze = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_err     <= 1'b0;
            Result_WB   <= '0;
            Dest_wb     <= '0;
            writeBackEn <= 1'b0;
            lat_load    <= 1'b0;
            lat_wb_en   <= 1'b0;
            lat_dest    <= '0;
        end else begin
            mem_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        // Read+write together is treated as a store.
                        mem_addr    <= alu_res_in - MEM_BASE;
                        mem_wdata   <= val_rm_in;
                        mem_we      <= mem_w_en_in;
                        lat_load    <= !mem_w_en_in;
                        lat_wb_en   <= wb_en_in;
                        lat_dest    <= dest_in;
                        mem_req     <= 1'b1;
                        writeBackEn <= 1'b0;
                        state       <= WAIT;
                    end else if (valid_in) begin
                        Result_WB   <= alu_res_in;
                        Dest_wb     <= dest_in;
                        writeBackEn <= wb_en_in;
                    end else begin
                        writeBackEn <= 1'b0;
                    end
                end
                WAIT: begin
                    // Ready wins over timeout in the same cycle.
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                        if (lat_load) begin
                            Result_WB   <= mem_rdata;
                            Dest_wb     <= lat_dest;
                            writeBackEn <= lat_wb_en;
                        end else begin
                            writeBackEn <= 1'b0;
                        end
                    end else if (timeout) begin
                        mem_req     <= 1'b0;
                        writeBackEn <= 1'b0;
                        mem_err     <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        writeBackEn <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
